// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and PC helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; the low two bits of a redirect target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] raw_pc);
    return raw_pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/Adder.sv
// Plain combinational adder, wrapping modulo 2^WIDTH.
module Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// registers each returned instruction for decode and honours redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_seq;
  logic         out_valid;
  logic         req_fire;
  logic         rsp_capture;

  // A request only goes out when the output register will be free by the time
  // the response returns, so a response never has to be stalled.
  assign imem_req_valid = (state == S_REQ) && !rst && (!out_valid || if_ready);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_capture    = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign if_valid       = out_valid;

  Adder #(.WIDTH(32)) u_pc_adder (
    .a (pc),
    .b (PC_STEP),
    .y (pc_seq)
  );

  Adder #(.WIDTH(32)) u_out_adder (
    .a (if_pc),
    .b (PC_STEP),
    .y (if_pc_plus4)
  );

  // Next-state: a redirect poisons whatever fetch is in flight or being accepted.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      S_REQ: begin
        if (req_fire) state_next = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT, S_DROP: begin
        if (imem_rsp_valid)      state_next = S_REQ;
        else if (redirect_valid) state_next = S_DROP;
      end
      default: state_next = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // PC and output register; redirect outranks capture, capture outranks consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      if_pc     <= 32'h0000_0000;
      if_instr  <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc        <= align_pc(redirect_pc);
      out_valid <= 1'b0;
    end else if (rsp_capture) begin
      pc        <= pc_seq;
      out_valid <= 1'b1;
      if_pc     <= pc;
      if_instr  <= imem_rsp_data;
    end else if (out_valid && if_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem model with programmable latency, a
// scoreboard of expected decode outputs, and cycle-accurate direct checks.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  logic        d2_req_valid;
  logic [31:0] d2_req_addr;
  logic        d2_if_valid;
  logic [31:0] d2_if_pc;
  logic [31:0] d2_if_instr;
  logic [31:0] d2_if_pc_plus4;

  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  exp_t sb[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4)
  );

  // Second copy starting at the top of the address space; it shares all inputs
  // and therefore runs in lockstep with the first, offset by -4 in PC.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (d2_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (d2_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (d2_if_valid),
    .if_ready       (if_ready),
    .if_pc          (d2_if_pc),
    .if_instr       (d2_if_instr),
    .if_pc_plus4    (d2_if_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Memory image: each word is derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, 16'h0013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    e.pc4   = a + 32'd4;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < budget);
    if (!if_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid actual=timeout required=if_valid");
    end
  endtask

  task automatic wait_pc(input logic [31:0] target, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if_valid && if_pc == target) && n < budget);
    if (!(if_valid && if_pc == target)) begin
      checks++;
      errors++;
      $display("FAIL wait_pc actual=timeout required=%h", target);
    end
  endtask

  task automatic wait_sb_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_sb_empty actual=%0d required=0", sb.size());
    end
  endtask

  // Instruction memory model: samples accepted requests on the falling edge,
  // answers exactly mem_lat cycles later, forgets everything on reset.
  initial begin
    logic        req_seen;
    logic [31:0] req_addr;
    logic        pending;
    logic [31:0] pend_addr;
    int          cnt;
    req_seen = 1'b0;
    req_addr = '0;
    pending  = 1'b0;
    pend_addr = '0;
    cnt = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        req_seen = 1'b1;
        req_addr = imem_req_addr;
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        req_seen = 1'b0;
        pending  = 1'b0;
      end else begin
        if (req_seen) begin
          pending   = 1'b1;
          pend_addr = req_addr;
          cnt       = mem_lat;
          req_seen  = 1'b0;
        end
        if (pending) begin
          if (cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pending        = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: every instruction decode consumes must be the next one expected.
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual_pc=%h required=none", if_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_pc", if_pc, e.pc);
        check("out_instr", if_instr, e.instr);
        check("out_pc_plus4", if_pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;

    // Reset state.
    repeat (3) tick();
    at_neg();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_if_pc_plus4", if_pc_plus4, 32'd4);
    check("rst_d2_req_valid", {31'd0, d2_req_valid}, 32'd0);
    check("rst_d2_pc_plus4", d2_if_pc_plus4, 32'd4);

    // Sequential fetch, 1-cycle memory.
    for (int a = 0; a <= 16; a += 4) push_exp(a);
    tick();
    rst = 1'b0;
    at_neg();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    check("d2_first_req_addr", d2_req_addr, 32'hFFFF_FFFC);

    wait_valid(10, n);
    check("first_valid_latency", n, 32'd2);
    check("d2_if_valid", {31'd0, d2_if_valid}, 32'd1);
    check("d2_if_pc", d2_if_pc, 32'hFFFF_FFFC);
    check("d2_if_instr", d2_if_instr, mem_word(32'h0));
    check("d2_wrap_pc_plus4", d2_if_pc_plus4, 32'h0);
    check("d2_wrap_next_addr", d2_req_addr, 32'h0);

    wait_pc(32'd12, 20, n);
    check("seq_throughput", n, 32'd6);

    // Backpressure on the next instruction.
    tick();
    if_ready = 1'b0;
    mem_lat  = 3;
    wait_valid(10, n);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        at_neg();
      end
      check("bp_if_valid", {31'd0, if_valid}, 32'd1);
      check("bp_if_pc", if_pc, 32'd16);
      check("bp_if_instr", if_instr, mem_word(32'd16));
      check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    tick();
    if_ready = 1'b1;
    at_neg();
    check("bp_release_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("bp_release_req_addr", imem_req_addr, 32'd20);

    // Redirect while waiting on a 3-cycle fetch.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    at_neg();
    check("rw_req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("rw_req_valid_drop", {31'd0, imem_req_valid}, 32'd0);
    check("rw_if_valid_drop", {31'd0, if_valid}, 32'd0);
    tick();
    at_neg();
    check("rw_stale_rsp_ignored", {31'd0, if_valid}, 32'd0);
    tick();
    at_neg();
    check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rw_req_addr", imem_req_addr, 32'h100);
    push_exp(32'h100);
    tick();
    imem_req_ready = 1'b0;
    wait_sb_empty(20);

    // Redirect with no handshake: address moves next cycle.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    at_neg();
    check("rn_req_addr_same", imem_req_addr, 32'h104);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("rn_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rn_req_addr", imem_req_addr, 32'h300);

    // Redirect coinciding with a request handshake; target low bits dropped.
    tick();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    mem_lat        = 1;
    at_neg();
    check("rh_fire_addr", imem_req_addr, 32'h300);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("rh_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    at_neg();
    check("rh_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rh_req_addr", imem_req_addr, 32'h200);
    push_exp(32'h200);
    tick();
    imem_req_ready = 1'b0;
    wait_sb_empty(20);

    // Redirect coinciding with a response.
    tick();
    imem_req_ready = 1'b1;
    mem_lat        = 2;
    at_neg();
    check("rr_req_addr", imem_req_addr, 32'h204);
    tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("rr_if_valid", {31'd0, if_valid}, 32'd0);
    check("rr_req_addr_new", imem_req_addr, 32'h400);
    tick();
    imem_req_ready = 1'b1;
    push_exp(32'h400);
    tick();
    imem_req_ready = 1'b0;
    wait_sb_empty(20);

    // Wrap at the top of the address space, held under backpressure.
    tick();
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    at_neg();
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_req_ready = 1'b0;
    wait_valid(10, n);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_if_instr", if_instr, mem_word(32'hFFFF_FFFC));
    check("wrap_pc_plus4", if_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_req_addr, 32'h0);
    tick();
    imem_req_ready = 1'b1;
    at_neg();
    check("wrap_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Redirect flushes a held output even though decode never took it.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    mem_lat        = 3;
    at_neg();
    check("flush_before", {31'd0, if_valid}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("flush_if_valid", {31'd0, if_valid}, 32'd0);
    check("flush_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("flush_req_addr", imem_req_addr, 32'h500);

    // Reset in the middle of a wait.
    tick();
    rst = 1'b1;
    at_neg();
    check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    at_neg();
    check("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("mid_rst_if_pc", if_pc, 32'h0);
    check("mid_rst_if_instr", if_instr, 32'h0000_0013);
    check("mid_rst_pc_plus4", if_pc_plus4, 32'd4);
    check("mid_rst_req_addr", imem_req_addr, 32'h0);
    check("mid_rst_d2_req_addr", d2_req_addr, 32'hFFFF_FFFC);
    tick();
    rst = 1'b0;
    at_neg();
    check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);
    repeat (6) tick();
    at_neg();
    check("post_rst_held_pc", if_pc, 32'h0);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
